// File: rtl/irr_priority_resolver.sv
// irr_priority_resolver: PIC interrupt-request front end.
// Synchronises IR7..IR0, holds the IRR, applies the mask, resolves the
// highest-priority unmasked request under a rotatable base against the
// current in-service bits, and runs the INT/INTA handshake with the CPU.
module irr_priority_resolver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_ir,
    input  logic       i_ltim,
    input  logic [7:0] i_imr,
    input  logic [7:0] i_isr_cur,
    input  logic       i_prio_load,
    input  logic [2:0] i_prio_base,
    input  logic       i_inta_pulse,
    output logic       o_int_out,
    output logic [7:0] o_isr_set,
    output logic [2:0] o_n,
    output logic [7:0] o_irr,
    output logic [2:0] o_vec_level,
    output logic       o_ack_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_ACK1 = 2'd2;

    logic [SYNC_STAGES-1:0][7:0] r_sync;
    logic [7:0]  r_irr;
    logic [7:0]  r_arm;
    logic [2:0]  r_base;
    logic [1:0]  r_state;
    logic        r_int_out;
    logic [7:0]  r_isr_set;
    logic [2:0]  r_vec_level;
    logic        r_ack_done;

    logic [7:0]  w_ir_s;
    logic [7:0]  w_masked;
    logic [15:0] w_masked_dbl;
    logic [15:0] w_isr_dbl;
    logic [7:0]  w_masked_rot;
    logic [7:0]  w_isr_rot;
    logic [2:0]  w_cand_rank;
    logic        w_cand_valid;
    logic [2:0]  w_cand;
    logic [2:0]  w_isr_rank;
    logic        w_isr_any;
    logic        w_req_valid;
    logic [1:0]  w_state_d;
    logic        w_grant;
    logic        w_spurious;
    logic        w_ack;
    logic [7:0]  w_grant_mask;
    logic [7:0]  w_irr_d;

    // Input synchroniser; deliberately not reset so that lines already high
    // during reset appear high (not low) afterwards and cannot arm an edge.
    always_ff @(posedge i_clk) begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], i_ir};
    end

    assign w_ir_s = r_sync[SYNC_STAGES-1];

    // Rotate request and in-service vectors so that bit j holds rank j.
    always_comb begin
        w_masked     = r_irr & ~i_imr;
        w_masked_dbl = {w_masked, w_masked} >> r_base;
        w_isr_dbl    = {i_isr_cur, i_isr_cur} >> r_base;
        w_masked_rot = w_masked_dbl[7:0];
        w_isr_rot    = w_isr_dbl[7:0];
    end

    // Lowest-rank set bit of each rotated vector (downward scan keeps the lowest).
    always_comb begin
        w_cand_rank  = 3'd0;
        w_cand_valid = 1'b0;
        w_isr_rank   = 3'd0;
        w_isr_any    = 1'b0;
        for (int j = 7; j >= 0; j--) begin
            if (w_masked_rot[j]) begin
                w_cand_rank  = 3'(j);
                w_cand_valid = 1'b1;
            end
            if (w_isr_rot[j]) begin
                w_isr_rank = 3'(j);
                w_isr_any  = 1'b1;
            end
        end
    end

    assign w_cand      = w_cand_rank + r_base;
    assign w_req_valid = w_cand_valid && (!w_isr_any || (w_cand_rank < w_isr_rank));

    // Handshake next-state and grant decode.
    always_comb begin
        w_state_d  = r_state;
        w_grant    = 1'b0;
        w_spurious = 1'b0;
        w_ack      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_valid) w_state_d = ST_REQ;
            end
            ST_REQ: begin
                if (i_inta_pulse) begin
                    w_state_d  = ST_ACK1;
                    w_grant    = w_req_valid;
                    w_spurious = !w_req_valid;
                end else if (!w_req_valid) begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_ACK1: begin
                if (i_inta_pulse) begin
                    w_state_d = ST_IDLE;
                    w_ack     = 1'b1;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // IRR next value: edge mode latches an armed rising line, level mode follows.
    always_comb begin
        w_grant_mask = w_grant ? (8'b1 << w_cand) : 8'b0;
        if (i_ltim) begin
            w_irr_d = w_ir_s & ~w_grant_mask;
        end else begin
            w_irr_d = (r_irr | (w_ir_s & r_arm)) & w_ir_s & ~w_grant_mask;
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_irr       <= 8'b0;
            r_arm       <= 8'b0;
            r_base      <= 3'd0;
            r_state     <= ST_IDLE;
            r_int_out   <= 1'b0;
            r_isr_set   <= 8'b0;
            r_vec_level <= 3'd0;
            r_ack_done  <= 1'b0;
        end else begin
            r_irr      <= w_irr_d;
            r_arm      <= ~w_ir_s;
            r_state    <= w_state_d;
            r_int_out  <= (w_state_d == ST_REQ);
            r_isr_set  <= w_grant_mask;
            r_ack_done <= w_ack;
            if (i_prio_load) r_base <= i_prio_base;
            if (w_grant) begin
                r_vec_level <= w_cand;
            end else if (w_spurious) begin
                r_vec_level <= 3'd7;
            end
        end
    end

    assign o_int_out   = r_int_out;
    assign o_isr_set   = r_isr_set;
    assign o_n         = r_base;
    assign o_irr       = r_irr;
    assign o_vec_level = r_vec_level;
    assign o_ack_done  = r_ack_done;

endmodule

// File: tb/tb_irr_priority_resolver.sv
// Bench for irr_priority_resolver: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural model.
module tb_irr_priority_resolver;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ir = 8'h00;
    logic       ltim = 1'b0;
    logic [7:0] imr = 8'h00;
    logic [7:0] isr_cur = 8'h00;
    logic       prio_load = 1'b0;
    logic [2:0] prio_base = 3'd0;
    logic       inta = 1'b0;

    logic       int_out;
    logic [7:0] isr_set;
    logic [2:0] n;
    logic [7:0] irr;
    logic [2:0] vec_level;
    logic       ack_done;

    int n_checks = 0;
    int n_err = 0;

    // Model state
    logic [7:0] m_q[$];
    int         m_state = 0;  // 0 idle, 1 waiting for first INTA, 2 waiting for second
    logic [7:0] m_irr = 0;
    logic [7:0] m_arm = 0;
    logic [2:0] m_base = 0;
    logic       m_int = 0;
    logic [7:0] m_isr_set = 0;
    logic [2:0] m_vec = 0;
    logic       m_ack = 0;

    always #5 clk = ~clk;

    irr_priority_resolver #(.SYNC_STAGES(S)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_ir         (ir),
        .i_ltim       (ltim),
        .i_imr        (imr),
        .i_isr_cur    (isr_cur),
        .i_prio_load  (prio_load),
        .i_prio_base  (prio_base),
        .i_inta_pulse (inta),
        .o_int_out    (int_out),
        .o_isr_set    (isr_set),
        .o_n          (n),
        .o_irr        (irr),
        .o_vec_level  (vec_level),
        .o_ack_done   (ack_done)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: predict from the rules, advance, compare every output.
    task automatic tick();
        logic [7:0] ir_smp, ir_s, masked, nirr, nset;
        int cand, cand_r, isr_r, ns, b, idx;
        bit grant, spur, ackp, rv;
        logic [2:0] nvec;
        ir_smp = ir;
        ir_s   = m_q[0];
        masked = m_irr & ~imr;
        b      = int'(m_base);
        cand   = 0;
        cand_r = 8;
        isr_r  = 8;
        for (int r = 0; r < 8; r++) begin
            idx = (r + b) % 8;
            if (cand_r == 8 && masked[idx]) begin
                cand   = idx;
                cand_r = r;
            end
            if (isr_r == 8 && isr_cur[idx]) isr_r = r;
        end
        rv    = (cand_r < isr_r);
        grant = 0;
        spur  = 0;
        ackp  = 0;
        ns    = m_state;
        case (m_state)
            0: if (rv) ns = 1;
            1: begin
                if (inta) begin
                    ns = 2;
                    if (rv) grant = 1; else spur = 1;
                end else if (!rv) ns = 0;
            end
            default: if (inta) begin ackp = 1; ns = 0; end
        endcase
        for (int i = 0; i < 8; i++) begin
            if (grant && i == cand) nirr[i] = 1'b0;
            else if (ltim) nirr[i] = ir_s[i];
            else if (!ir_s[i]) nirr[i] = 1'b0;
            else if (m_arm[i]) nirr[i] = 1'b1;
            else nirr[i] = m_irr[i];
        end
        nset = grant ? (8'h01 << cand) : 8'h00;
        nvec = grant ? 3'(cand) : (spur ? 3'd7 : m_vec);

        @(posedge clk);
        #1;
        m_q.push_back(ir_smp);
        void'(m_q.pop_front());
        if (reset) begin
            m_state = 0; m_irr = 0; m_arm = 0; m_base = 0;
            m_int = 0; m_isr_set = 0; m_vec = 0; m_ack = 0;
        end else begin
            m_arm     = ~ir_s;
            m_irr     = nirr;
            if (prio_load) m_base = prio_base;
            m_state   = ns;
            m_int     = (ns == 1);
            m_isr_set = nset;
            m_vec     = nvec;
            m_ack     = ackp;
        end
        chk("model_int_out", {7'd0, int_out}, {7'd0, m_int});
        chk("model_isr_set", isr_set, m_isr_set);
        chk("model_n", {5'd0, n}, {5'd0, m_base});
        chk("model_irr", irr, m_irr);
        chk("model_vec_level", {5'd0, vec_level}, {5'd0, m_vec});
        chk("model_ack_done", {7'd0, ack_done}, {7'd0, m_ack});
    endtask

    task automatic ticks(input int cnt);
        for (int k = 0; k < cnt; k++) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_int"}, {7'd0, int_out}, 8'h00);
        chk({tag, "_isr_set"}, isr_set, 8'h00);
        chk({tag, "_n"}, {5'd0, n}, 8'h00);
        chk({tag, "_vec"}, {5'd0, vec_level}, 8'h00);
        chk({tag, "_ack"}, {7'd0, ack_done}, 8'h00);
        chk({tag, "_irr"}, irr, 8'h00);
    endtask

    initial begin
        for (int k = 0; k < S; k++) m_q.push_back(8'h00);

        // Reset state
        ticks(3);
        chk_all_zero("reset");
        reset = 1'b0;

        // Basic grant
        ir = 8'h06;
        ticks(3);
        chk("basic_irr", irr, 8'h06);
        tick();
        chk("basic_int", {7'd0, int_out}, 8'h01);
        inta = 1'b1; tick(); inta = 1'b0;
        chk("basic_isr_set", isr_set, 8'h02);
        chk("basic_vec", {5'd0, vec_level}, 8'h01);
        chk("basic_irr_clr", irr, 8'h04);
        chk("basic_int_low", {7'd0, int_out}, 8'h00);
        tick();
        chk("isr_set_one_cycle", isr_set, 8'h00);
        inta = 1'b1; tick(); inta = 1'b0;
        chk("basic_ack", {7'd0, ack_done}, 8'h01);
        tick();
        chk("ack_one_cycle", {7'd0, ack_done}, 8'h00);
        chk("next_pending_int", {7'd0, int_out}, 8'h01);
        inta = 1'b1; tick(); inta = 1'b0;
        chk("second_isr_set", isr_set, 8'h04);
        chk("second_vec", {5'd0, vec_level}, 8'h02);
        inta = 1'b1; tick(); inta = 1'b0;
        ir = 8'h00;
        ticks(4);
        chk("basic_idle_int", {7'd0, int_out}, 8'h00);

        // Rotation
        prio_base = 3'd3; prio_load = 1'b1; tick(); prio_load = 1'b0;
        chk("rot_n", {5'd0, n}, 8'h03);
        ir = 8'h1C;
        ticks(3);
        chk("rot_irr", irr, 8'h1C);
        tick();
        chk("rot_int", {7'd0, int_out}, 8'h01);
        inta = 1'b1; tick(); inta = 1'b0;
        isr_cur = 8'h08;
        chk("rot_isr_set", isr_set, 8'h08);
        chk("rot_vec", {5'd0, vec_level}, 8'h03);
        ir = 8'h18;
        inta = 1'b1; tick(); inta = 1'b0;
        chk("rot_ack", {7'd0, ack_done}, 8'h01);
        ticks(4);
        chk("rot_pending", irr, 8'h10);
        chk("rot_blocked", {7'd0, int_out}, 8'h00);

        // Nesting
        prio_base = 3'd0; prio_load = 1'b1; isr_cur = 8'h10; ir = 8'h04;
        tick(); prio_load = 1'b0;
        chk("nest_n", {5'd0, n}, 8'h00);
        ticks(2);
        chk("nest_irr", irr, 8'h04);
        tick();
        chk("nest_int", {7'd0, int_out}, 8'h01);
        isr_cur = 8'h02; tick();
        chk("nest_blocked", {7'd0, int_out}, 8'h00);
        isr_cur = 8'h00; tick();
        chk("nest_unblocked", {7'd0, int_out}, 8'h01);
        inta = 1'b1; tick();
        chk("nest_isr_set", isr_set, 8'h04);
        tick(); inta = 1'b0;
        chk("nest_ack", {7'd0, ack_done}, 8'h01);
        ir = 8'h00;
        ticks(4);

        // Spurious
        ir = 8'h20;
        ticks(3);
        chk("spur_irr", irr, 8'h20);
        tick();
        chk("spur_int", {7'd0, int_out}, 8'h01);
        ir = 8'h00;
        ticks(4);
        chk("spur_drop_irr", irr, 8'h00);
        chk("spur_drop_int", {7'd0, int_out}, 8'h00);
        inta = 1'b1; tick(); inta = 1'b0;
        chk("idle_inta_ack", {7'd0, ack_done}, 8'h00);
        chk("idle_inta_isr", isr_set, 8'h00);
        chk("vec_hold", {5'd0, vec_level}, 8'h02);
        ir = 8'h20;
        ticks(4);
        chk("spur2_int", {7'd0, int_out}, 8'h01);
        imr = 8'h20; inta = 1'b1; tick(); inta = 1'b0;
        chk("spur_vec", {5'd0, vec_level}, 8'h07);
        chk("spur_isr_set", isr_set, 8'h00);
        chk("spur_int_low", {7'd0, int_out}, 8'h00);
        inta = 1'b1; tick(); inta = 1'b0;
        chk("spur_ack", {7'd0, ack_done}, 8'h01);
        ir = 8'h00; imr = 8'h00;
        ticks(6);
        chk("spur_end_int", {7'd0, int_out}, 8'h00);

        // Edge mode: held line does not re-trigger
        ir = 8'h01;
        ticks(4);
        chk("edge_int", {7'd0, int_out}, 8'h01);
        inta = 1'b1; tick(); inta = 1'b0;
        chk("edge_isr_set", isr_set, 8'h01);
        chk("edge_irr_clr", irr, 8'h00);
        inta = 1'b1; tick(); inta = 1'b0;
        ticks(3);
        chk("edge_no_retrig", irr, 8'h00);
        chk("edge_no_int", {7'd0, int_out}, 8'h00);

        // Level mode: held line re-requests right after the grant
        ir = 8'h00;
        ticks(4);
        ltim = 1'b1; ir = 8'h01;
        ticks(3);
        chk("lvl_irr", irr, 8'h01);
        tick();
        chk("lvl_int", {7'd0, int_out}, 8'h01);
        inta = 1'b1; tick(); inta = 1'b0;
        chk("lvl_isr_set", isr_set, 8'h01);
        chk("lvl_irr_forced", irr, 8'h00);
        tick();
        chk("lvl_irr_back", irr, 8'h01);
        inta = 1'b1; tick(); inta = 1'b0;
        chk("lvl_ack", {7'd0, ack_done}, 8'h01);
        tick();
        chk("lvl_reassert", {7'd0, int_out}, 8'h01);
        inta = 1'b1; tick(); inta = 1'b0;
        chk("lvl_isr_set2", isr_set, 8'h01);

        // Reset mid-ACK1
        reset = 1'b1; tick(); reset = 1'b0;
        chk_all_zero("mid_reset");
        inta = 1'b1; tick(); inta = 1'b0;
        chk("post_reset_ack", {7'd0, ack_done}, 8'h00);
        chk("post_reset_isr", isr_set, 8'h00);

        // Edge mode: lines high through reset never trigger until they drop
        ltim = 1'b0; ir = 8'hFF; reset = 1'b1;
        ticks(3);
        reset = 1'b0;
        ticks(5);
        chk("high_at_reset", irr, 8'h00);
        ir = 8'h00;
        ticks(3);
        ir = 8'hFF;
        ticks(3);
        chk("rearm_irr", irr, 8'hFF);

        // Random phase
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if (c % 1000 == 0) ltim = 1'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 9) == 0) ir[i] = ~ir[i];
            if ($urandom_range(0, 15) == 0)
                imr = ($urandom_range(0, 2) == 0) ? 8'($urandom()) : 8'h00;
            if ($urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 2))
                    0: isr_cur = 8'h00;
                    1: isr_cur = 8'h01 << $urandom_range(0, 7);
                    default: isr_cur = 8'($urandom());
                endcase
            end
            prio_load = ($urandom_range(0, 19) == 0);
            prio_base = 3'($urandom());
            inta = ($urandom_range(0, 2) == 0);
            tick();
        end
        reset = 1'b0; inta = 1'b0; prio_load = 1'b0;
        ticks(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
